mem_handle_server: RTL

MEM_HANDLE_SERVER -- requirements
Module: mem_handle_server

---
 rtl/mem_handle_server.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mem_handle_server.sv
// Round-robin server multiplexing NCH client channels onto one synchronous single-port SRAM.
// Define MEM_HANDLE_SERVER_BOUNDS_EN to add per-channel region inputs and the sticky err flag.
module mem_handle_server #(
  parameter int NCH = 4,
  parameter int AW  = 16
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic [NCH-1:0]       avail,
  input  logic [NCH-1:0]       r_en,
  input  logic [NCH-1:0]       w_en,
  input  logic [NCH-1:0][31:0] ptr,
  input  logic [NCH-1:0][31:0] data_store,
`ifdef MEM_HANDLE_SERVER_BOUNDS_EN
  input  logic [NCH-1:0][31:0] region_begin,
  input  logic [NCH-1:0][31:0] region_end,
`endif
  output logic [NCH-1:0]       done,
  output logic [NCH-1:0][31:0] data_load,
  output logic [AW-1:0]        mem_addr,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  output logic                 err
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SW = CW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        gnt_q, gnt_d;
  logic [CW-1:0]        last_q, last_d;
  logic                 op_rd_q, op_rd_d;
  logic                 oob_q, oob_d;
  logic [AW-1:0]        mem_addr_q, mem_addr_d;
  logic                 mem_rd_q, mem_rd_d;
  logic                 mem_wr_q, mem_wr_d;
  logic [31:0]          mem_wdata_q, mem_wdata_d;
  logic [NCH-1:0]       done_q, done_d;
  logic [NCH-1:0][31:0] data_load_q, data_load_d;
  logic                 err_q, err_d;

  logic [NCH-1:0]       elig;
  logic                 any_elig;
  logic [CW-1:0]        pick;
  logic [SW-1:0]        cand;
  logic [NCH-1:0]       oob_vec;

  assign elig     = avail & ~done_q;
  assign any_elig = |elig;

`ifdef MEM_HANDLE_SERVER_BOUNDS_EN
  // Region is half-open: [region_begin, region_end).
  always_comb begin
    oob_vec = {NCH{1'b0}};
    for (int c = 0; c < NCH; c++) begin
      oob_vec[c] = (ptr[c] < region_begin[c]) || (ptr[c] >= region_end[c]);
    end
  end
`else
  logic unused_ptr;
  assign oob_vec    = {NCH{1'b0}};
  assign unused_ptr = ^ptr;
`endif

  // Walk from the farthest candidate back to last+1 so the nearest eligible one wins.
  always_comb begin
    pick = last_q;
    cand = {SW{1'b0}};
    for (int i = NCH; i >= 1; i--) begin
      cand = {1'b0, last_q} + SW'(i);
      cand = (cand >= SW'(NCH)) ? (cand - SW'(NCH)) : cand;
      pick = elig[cand[CW-1:0]] ? cand[CW-1:0] : pick;
    end
  end

  // Next-state and datapath updates for the single in-flight transaction.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    op_rd_d     = op_rd_q;
    oob_d       = oob_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    done_d      = done_q;
    data_load_d = data_load_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (any_elig) begin
          gnt_d       = pick;
          last_d      = pick;
          op_rd_d     = r_en[pick] & ~w_en[pick];
          oob_d       = oob_vec[pick];
          mem_addr_d  = ptr[pick][AW-1:0];
          mem_wdata_d = data_store[pick];
          mem_rd_d    = r_en[pick] & ~w_en[pick] & ~oob_vec[pick];
          mem_wr_d    = w_en[pick] & ~oob_vec[pick];
          err_d       = err_q | oob_vec[pick];
          state_d     = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (!avail[gnt_q]) begin
          state_d = IDLE;
        end else if (op_rd_q) begin
          state_d = CAPTURE;
        end else begin
          done_d[gnt_q] = 1'b1;
          state_d       = ACK;
        end
      end
      CAPTURE: begin
        if (!avail[gnt_q]) begin
          state_d = IDLE;
        end else begin
          data_load_d[gnt_q] = oob_q ? 32'd0 : mem_rdata;
          done_d[gnt_q]      = 1'b1;
          state_d            = ACK;
        end
      end
      ACK: begin
        if (!avail[gnt_q]) begin
          done_d[gnt_q] = 1'b0;
          state_d       = IDLE;
        end else begin
          state_d = ACK;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= IDLE;
      gnt_q       <= {CW{1'b0}};
      last_q      <= CW'(NCH - 1);
      op_rd_q     <= 1'b0;
      oob_q       <= 1'b0;
      mem_addr_q  <= {AW{1'b0}};
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= 32'd0;
      done_q      <= {NCH{1'b0}};
      data_load_q <= {NCH{32'd0}};
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      op_rd_q     <= op_rd_d;
      oob_q       <= oob_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      data_load_q <= data_load_d;
      err_q       <= err_d;
    end
  end

  assign done      = done_q;
  assign data_load = data_load_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;

endmodule
